// File: rtl/vga_scanout_timing_if.sv
// Scan-side pixel interface: counters out to the frame-buffer controller, colour back, VGA pins out.
// TEST_PATTERN_EN adds the test_pattern select.
interface vga_scanout_timing_if;
    logic [9:0] counter_H;
    logic [9:0] counter_V;
    logic       colour;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic       vblank;
    logic       frame_start;
`ifdef TEST_PATTERN_EN
    logic       test_pattern;

    modport master (
        output counter_H, counter_V, hsync, vsync, rgb, vblank, frame_start,
        input  colour, test_pattern
    );
    modport slave (
        input  counter_H, counter_V, hsync, vsync, rgb, vblank, frame_start,
        output colour, test_pattern
    );
`else
    modport master (
        output counter_H, counter_V, hsync, vsync, rgb, vblank, frame_start,
        input  colour
    );
    modport slave (
        input  counter_H, counter_V, hsync, vsync, rgb, vblank, frame_start,
        output colour
    );
`endif
endinterface

// File: rtl/vga_scanout_timing.sv
// VGA scan timing: pixel/line counters, sync and blanking delayed to match the colour return latency.
// Optional macro TEST_PATTERN_EN replaces colour with a 40x40 checkerboard while test_pattern is high.
module vga_scanout_timing #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int PIPE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_scanout_timing_if.master vga
);

    localparam int H_TOTAL_I = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_I = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL_I - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL_I - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    if (PIPE_LATENCY < 1 || PIPE_LATENCY > 4) begin : g_bad_latency
        $error("vga_scanout_timing: PIPE_LATENCY must be in 1..4");
    end

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       h_wrap, v_wrap;
    logic       active_raw, hs_n_raw, vs_n_raw;

    logic [PIPE_LATENCY-1:0] act_pipe_q;
    logic [PIPE_LATENCY-1:0] hs_pipe_q;
    logic [PIPE_LATENCY-1:0] vs_pipe_q;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;
    logic       frame_start_q, frame_start_d;
    logic       pix;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? 10'd0 : v_q + 10'd1;
        end
        active_raw = (h_q < H_VIS) && (v_q < V_VIS);
        hs_n_raw   = !((h_q >= HS_START) && (h_q < HS_END));
        vs_n_raw   = !((v_q >= VS_START) && (v_q < VS_END));
    end

`ifdef TEST_PATTERN_EN
    // Only the tile parity is needed for the checkerboard, so the tile counters are 1 bit.
    logic [5:0] px_cnt_q, px_cnt_d;
    logic [5:0] ln_cnt_q, ln_cnt_d;
    logic       tile_x_q, tile_x_d;
    logic       tile_y_q, tile_y_d;
    logic [PIPE_LATENCY-1:0] pat_pipe_q;

    always_comb begin
        px_cnt_d = px_cnt_q + 6'd1;
        tile_x_d = tile_x_q;
        ln_cnt_d = ln_cnt_q;
        tile_y_d = tile_y_q;
        if (h_wrap) begin
            px_cnt_d = 6'd0;
            tile_x_d = 1'b0;
            ln_cnt_d = ln_cnt_q + 6'd1;
            if (v_wrap) begin
                ln_cnt_d = 6'd0;
                tile_y_d = 1'b0;
            end else if (ln_cnt_q == 6'd39) begin
                ln_cnt_d = 6'd0;
                tile_y_d = ~tile_y_q;
            end
        end else if (px_cnt_q == 6'd39) begin
            px_cnt_d = 6'd0;
            tile_x_d = ~tile_x_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            px_cnt_q   <= 6'd0;
            ln_cnt_q   <= 6'd0;
            tile_x_q   <= 1'b0;
            tile_y_q   <= 1'b0;
            pat_pipe_q <= '0;
        end else begin
            px_cnt_q      <= px_cnt_d;
            ln_cnt_q      <= ln_cnt_d;
            tile_x_q      <= tile_x_d;
            tile_y_q      <= tile_y_d;
            pat_pipe_q[0] <= tile_x_q ^ tile_y_q;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                pat_pipe_q[i] <= pat_pipe_q[i-1];
            end
        end
    end

    assign pix = vga.test_pattern ? pat_pipe_q[PIPE_LATENCY-1] : vga.colour;
`else
    assign pix = vga.colour;
`endif

    always_comb begin
        hsync_d       = hs_pipe_q[PIPE_LATENCY-1];
        vsync_d       = vs_pipe_q[PIPE_LATENCY-1];
        rgb_d         = act_pipe_q[PIPE_LATENCY-1] ? {6{pix}} : 6'd0;
        frame_start_d = h_wrap && v_wrap;
    end

    // Pipeline resets to blanked/sync-inactive so a mid-frame reset cannot glitch the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
        end else begin
            act_pipe_q[0] <= active_raw;
            hs_pipe_q[0]  <= hs_n_raw;
            vs_pipe_q[0]  <= vs_n_raw;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                act_pipe_q[i] <= act_pipe_q[i-1];
                hs_pipe_q[i]  <= hs_pipe_q[i-1];
                vs_pipe_q[i]  <= vs_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 6'd0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.counter_H   = h_q;
    assign vga.counter_V   = v_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.rgb         = rgb_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank      = (v_q >= V_VIS);

endmodule
